// File: rtl/instr_sequencer.sv
// instr_sequencer
// Program sequencer in front of the RISC-V datapath. A small instruction
// store is filled through the load port. A run then issues words 0..n-1 to
// the datapath one at a time. Each word is held for HOLD_CYCLES clocks, and
// NOP_WORD is driven at all other times. A run ends when the word count is
// exhausted, when HALT_WORD is met, or on abort. HALT_WORD is never issued.
//
// Ports
//   clk_i           system clock, rising edge
//   reset_ni        asynchronous active-low reset
//   load_we_i       store write strobe (ignored while running)
//   load_addr_i     store write address
//   load_data_i     store write data
//   num_inst_i      words to run, sampled at start, clamped to DEPTH
//   start_i         begin a run (sampled only when not running)
//   abort_i         cancel an active run
//   instruction_o   word to the datapath
//   instr_valid_o   instruction_o carries a program word
//   issue_idx_o     store index currently issued
//   issued_count_o  program words issued in the current/last run
//   busy_o          run in progress
//   done_o          run finished (level)
//   halted_o        last run ended on HALT_WORD
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | no run active; after reset or abort
// S_RUN  | issuing words; the hold timer counts down per word
// S_DONE | run finished; final index/count are kept until the next start
module instr_sequencer #(
  parameter int          DEPTH       = 16,
  parameter int          ADDR_W      = 4,
  parameter int          HOLD_CYCLES = 1,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0013,
  parameter logic [31:0] HALT_WORD   = 32'h0000_0073
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              load_we_i,
  input  logic [ADDR_W-1:0] load_addr_i,
  input  logic [31:0]       load_data_i,
  input  logic [ADDR_W:0]   num_inst_i,
  input  logic              start_i,
  input  logic              abort_i,
  output logic [31:0]       instruction_o,
  output logic              instr_valid_o,
  output logic [ADDR_W-1:0] issue_idx_o,
  output logic [ADDR_W:0]   issued_count_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              halted_o
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE    = HOLD_W'(1);
  localparam logic [ADDR_W:0]   DEPTH_C     = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   ONE_C       = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       instr_q, instr_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              halted_q, halted_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [ADDR_W:0]   n_q, n_d;

  logic [31:0]       mem_q [DEPTH];

  logic [ADDR_W:0]   n_start;
  logic [31:0]       word0;
  logic [ADDR_W:0]   k;
  logic [31:0]       word_k;

  // The store has no reset, so its contents survive a reset.
  always_ff @(posedge clk_i) begin
    if (load_we_i && (state_q != S_RUN)) begin
      mem_q[load_addr_i] <= load_data_i;
    end
  end

  assign n_start = (num_inst_i > DEPTH_C) ? DEPTH_C : num_inst_i;
  // A write to address 0 on the start edge is forwarded, so the first
  // issued word is the one being written on that edge.
  assign word0   = (load_we_i && (load_addr_i == '0)) ? load_data_i : mem_q[0];
  assign k       = {1'b0, idx_q} + ONE_C;
  assign word_k  = mem_q[k[ADDR_W-1:0]];

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= S_IDLE;
      instr_q  <= NOP_WORD;
      valid_q  <= 1'b0;
      idx_q    <= '0;
      cnt_q    <= '0;
      halted_q <= 1'b0;
      hold_q   <= '0;
      n_q      <= '0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      halted_q <= halted_d;
      hold_q   <= hold_d;
      n_q      <= n_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    halted_d = halted_q;
    hold_d   = hold_q;
    n_d      = n_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          idx_d    = '0;
          cnt_d    = '0;
          halted_d = 1'b0;
          instr_d  = NOP_WORD;
          valid_d  = 1'b0;
          n_d      = n_start;
          if (n_start == '0) begin
            state_d = S_DONE;
          end else if (word0 == HALT_WORD) begin
            state_d  = S_DONE;
            halted_d = 1'b1;
          end else begin
            state_d = S_RUN;
            instr_d = word0;
            valid_d = 1'b1;
            cnt_d   = ONE_C;
            hold_d  = HOLD_RELOAD;
          end
        end
      end

      S_RUN: begin
        // Abort wins over hold expiry.
        if (abort_i) begin
          state_d  = S_IDLE;
          instr_d  = NOP_WORD;
          valid_d  = 1'b0;
          halted_d = 1'b0;
        end else if (hold_q != '0) begin
          hold_d = hold_q - HOLD_ONE;
        end else if (k == n_q) begin
          state_d = S_DONE;
          instr_d = NOP_WORD;
          valid_d = 1'b0;
        end else if (word_k == HALT_WORD) begin
          state_d  = S_DONE;
          instr_d  = NOP_WORD;
          valid_d  = 1'b0;
          halted_d = 1'b1;
        end else begin
          instr_d = word_k;
          idx_d   = k[ADDR_W-1:0];
          cnt_d   = cnt_q + ONE_C;
          hold_d  = HOLD_RELOAD;
        end
      end

      default: begin
        state_d = S_IDLE;
        instr_d = NOP_WORD;
        valid_d = 1'b0;
      end
    endcase
  end

  assign instruction_o  = instr_q;
  assign instr_valid_o  = valid_q;
  assign issue_idx_o    = idx_q;
  assign issued_count_o = cnt_q;
  assign busy_o         = (state_q == S_RUN);
  assign done_o         = (state_q == S_DONE);
  assign halted_o       = halted_q;

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] HALT = 32'h0000_0073;

  logic        clk, rst_n;
  logic        load_we;
  logic [3:0]  load_addr;
  logic [31:0] load_data;
  logic [4:0]  num_inst;
  logic        start, abort;

  // index 0: HOLD_CYCLES=1, index 1: HOLD_CYCLES=2
  logic [31:0] instr  [2];
  logic        valid  [2];
  logic [3:0]  idx    [2];
  logic [4:0]  cnt    [2];
  logic        busy   [2];
  logic        done   [2];
  logic        halted [2];

  int checks = 0;
  int errors = 0;

  instr_sequencer #(.HOLD_CYCLES(1)) u_dut0 (
    .clk_i(clk), .reset_ni(rst_n), .load_we_i(load_we), .load_addr_i(load_addr),
    .load_data_i(load_data), .num_inst_i(num_inst), .start_i(start), .abort_i(abort),
    .instruction_o(instr[0]), .instr_valid_o(valid[0]), .issue_idx_o(idx[0]),
    .issued_count_o(cnt[0]), .busy_o(busy[0]), .done_o(done[0]), .halted_o(halted[0]));

  instr_sequencer #(.HOLD_CYCLES(2)) u_dut1 (
    .clk_i(clk), .reset_ni(rst_n), .load_we_i(load_we), .load_addr_i(load_addr),
    .load_data_i(load_data), .num_inst_i(num_inst), .start_i(start), .abort_i(abort),
    .instruction_o(instr[1]), .instr_valid_o(valid[1]), .issue_idx_o(idx[1]),
    .issued_count_o(cnt[1]), .busy_o(busy[1]), .done_o(done[1]), .halted_o(halted[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // Run-level model: at start, scan the store for the program length and
  // whether a halt word ends it; afterwards the outputs follow from the
  // elapsed cycle count alone.
  logic [31:0] m_mem [2][16];
  bit m_active [2] = '{0, 0};
  bit m_done   [2] = '{0, 0};
  bit m_halted [2] = '{0, 0};
  bit m_rhalt  [2] = '{0, 0};
  int m_idx    [2] = '{0, 0};
  int m_cnt    [2] = '{0, 0};
  int m_len    [2] = '{0, 0};
  int m_c      [2] = '{0, 0};

  function automatic int hold_of(input int i);
    return (i == 0) ? 1 : 2;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_active[i] = 0; m_done[i] = 0; m_halted[i] = 0;
        m_idx[i] = 0; m_cnt[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (m_active[i]) begin
          if (abort) begin
            m_active[i] = 0; m_done[i] = 0; m_halted[i] = 0;
          end else begin
            m_c[i]++;
            if (m_c[i] == m_len[i] * hold_of(i)) begin
              m_active[i] = 0; m_done[i] = 1; m_halted[i] = m_rhalt[i];
            end else begin
              m_idx[i] = m_c[i] / hold_of(i);
              m_cnt[i] = m_idx[i] + 1;
            end
          end
        end else begin
          if (load_we) m_mem[i][load_addr] = load_data;
          if (start) begin
            int n;
            n = (num_inst > 16) ? 16 : int'(num_inst);
            m_len[i] = 0;
            while (m_len[i] < n && m_mem[i][m_len[i]] != HALT) m_len[i]++;
            m_rhalt[i] = (m_len[i] < n);
            m_idx[i] = 0;
            m_halted[i] = 0;
            if (m_len[i] == 0) begin
              m_done[i] = 1; m_halted[i] = m_rhalt[i]; m_cnt[i] = 0;
            end else begin
              m_active[i] = 1; m_c[i] = 0; m_cnt[i] = 1; m_done[i] = 0;
            end
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("instr[%0d]", i), instr[i], m_active[i] ? m_mem[i][m_idx[i]] : NOP);
      chk($sformatf("valid[%0d]", i), 32'(valid[i]), 32'(m_active[i]));
      chk($sformatf("busy[%0d]", i), 32'(busy[i]), 32'(m_active[i]));
      chk($sformatf("done[%0d]", i), 32'(done[i]), 32'(m_done[i]));
      chk($sformatf("halted[%0d]", i), 32'(halted[i]), 32'(m_halted[i]));
      chk($sformatf("idx[%0d]", i), 32'(idx[i]), 32'(m_idx[i]));
      chk($sformatf("cnt[%0d]", i), 32'(cnt[i]), 32'(m_cnt[i]));
      chk($sformatf("no_halt_issued[%0d]", i), 32'(instr[i] == HALT), 32'd0);
    end
  end

  task automatic load(input int a, input logic [31:0] d);
    load_we = 1'b1; load_addr = 4'(a); load_data = d;
    @(negedge clk);
    load_we = 1'b0;
  endtask

  task automatic pulse_start(input int n);
    num_inst = 5'(n); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_both(input int budget);
    int cyc = 0;
    while ((busy[0] || busy[1]) && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    chk("wait_idle_timeout", {30'd0, busy[1], busy[0]}, 32'd0);
    @(negedge clk);
  endtask

  function automatic logic [31:0] run_dp(input logic [31:0] w0, w1, w2);
    logic [31:0] rf [32];
    logic [31:0] ws [3];
    logic [31:0] w;
    for (int r = 0; r < 32; r++) rf[r] = '0;
    ws[0] = w0; ws[1] = w1; ws[2] = w2;
    for (int j = 0; j < 3; j++) begin
      w = ws[j];
      if (w[6:0] == 7'h13)
        rf[w[11:7]] = rf[w[19:15]] + {{20{w[31]}}, w[31:20]};
      else if (w[6:0] == 7'h33)
        rf[w[11:7]] = rf[w[19:15]] + rf[w[24:20]];
      rf[0] = '0;
    end
    return rf[3];
  endfunction

  logic [31:0] cap [3];

  initial begin
    rst_n = 1'b0; load_we = 0; load_addr = '0; load_data = '0;
    num_inst = '0; start = 0; abort = 0;
    repeat (2) @(negedge clk);
    chk("rst_instr", instr[0], NOP);
    chk("rst_valid", 32'(valid[0]), 32'd0);
    chk("rst_cnt", 32'(cnt[0]), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // three-word program, HOLD=1
    load(0, 32'h0050_0093);
    load(1, 32'h0070_0113);
    load(2, 32'h0020_81B3);
    pulse_start(3);
    cap[0] = instr[0]; chk("t1_w0", instr[0], 32'h0050_0093);
    chk("t1_valid0", 32'(valid[0]), 32'd1);
    @(negedge clk); cap[1] = instr[0]; chk("t1_w1", instr[0], 32'h0070_0113);
    @(negedge clk); cap[2] = instr[0]; chk("t1_w2", instr[0], 32'h0020_81B3);
    @(negedge clk);
    chk("t1_nop", instr[0], NOP);
    chk("t1_done", 32'(done[0]), 32'd1);
    chk("t1_cnt", 32'(cnt[0]), 32'd3);
    chk("t1_x3", run_dp(cap[0], cap[1], cap[2]), 32'h0000_000C);
    wait_both(20);

    // halt word at index 2
    load(0, 32'h0010_0093);
    load(1, 32'h0020_0113);
    load(2, HALT);
    pulse_start(5);
    wait_both(20);
    chk("t2_halted0", 32'(halted[0]), 32'd1);
    chk("t2_done0", 32'(done[0]), 32'd1);
    chk("t2_cnt0", 32'(cnt[0]), 32'd2);
    chk("t2_cnt1", 32'(cnt[1]), 32'd2);

    // HOLD=2 instance: each word held two clocks, done 4 cycles after first issue
    pulse_start(2);
    chk("t3_c1", instr[1], 32'h0010_0093);
    @(negedge clk); chk("t3_c2", instr[1], 32'h0010_0093);
    chk("t3_c2_done", 32'(done[1]), 32'd0);
    @(negedge clk); chk("t3_c3", instr[1], 32'h0020_0113);
    @(negedge clk); chk("t3_c4", instr[1], 32'h0020_0113);
    chk("t3_c4_done", 32'(done[1]), 32'd0);
    @(negedge clk); chk("t3_c5_done", 32'(done[1]), 32'd1);
    chk("t3_c5_nop", instr[1], NOP);
    wait_both(20);

    // abort at issue_idx 1 of 4, then restart
    load(0, 32'h0010_0093);
    load(1, 32'h0020_0113);
    load(2, 32'h0030_0193);
    load(3, 32'h0040_0213);
    pulse_start(4);
    chk("t4_idx0", 32'(idx[0]), 32'd0);
    @(negedge clk); chk("t4_idx1", 32'(idx[0]), 32'd1);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("t4_busy", 32'(busy[0]), 32'd0);
    chk("t4_instr", instr[0], NOP);
    chk("t4_done", 32'(done[0]), 32'd0);
    chk("t4_cnt", 32'(cnt[0]), 32'd2);
    pulse_start(4);
    chk("t4_restart_idx", 32'(idx[0]), 32'd0);
    chk("t4_restart_w", instr[0], 32'h0010_0093);
    wait_both(30);

    // num_inst=0, then clamp of 20 to 16
    pulse_start(0);
    chk("t5_done0", 32'(done[0]), 32'd1);
    chk("t5_valid0", 32'(valid[0]), 32'd0);
    chk("t5_cnt0", 32'(cnt[0]), 32'd0);
    for (int i = 0; i < 16; i++) load(i, 32'h0000_0093 | (32'(i) << 20));
    pulse_start(20);
    wait_both(60);
    chk("t5_cnt_clamp0", 32'(cnt[0]), 32'd16);
    chk("t5_cnt_clamp1", 32'(cnt[1]), 32'd16);
    chk("t5_idx_last", 32'(idx[0]), 32'd15);

    // write during RUN is ignored
    pulse_start(4);
    load(1, 32'hDEAD_BEEF);
    wait_both(20);
    pulse_start(4);
    @(negedge clk);
    chk("t6_mem1_kept", instr[0], 32'h0010_0093);

    // async reset mid-run
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("t6_rst_instr[%0d]", i), instr[i], NOP);
      chk($sformatf("t6_rst_valid[%0d]", i), 32'(valid[i]), 32'd0);
      chk($sformatf("t6_rst_busy[%0d]", i), 32'(busy[i]), 32'd0);
      chk($sformatf("t6_rst_idx[%0d]", i), 32'(idx[i]), 32'd0);
      chk($sformatf("t6_rst_cnt[%0d]", i), 32'(cnt[i]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start(1);
    chk("t6_store_survives", instr[0], 32'h0000_0093);
    wait_both(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
